// File: rtl/generic_sram_dp.sv
// generic_sram_dp
// Technology-independent true dual-port synchronous SRAM, 2**abits words of
// dbits bits, used as the storage core behind tech-mapped BRAM wrappers.
// Both ports are symmetric. A port with we=1 writes d to a. Every port
// registers a read of its address on every rising edge, so q lags a by one cycle.
// If both ports write the same address in one cycle, port 1 wins.
// rstn is an asynchronous, active-low reset. It clears only the read registers.
// The array contents are kept across reset.
// Optional macro GENERIC_SRAM_WRITE_FIRST_EN selects write-first (forwarding)
// read behaviour. When it is undefined, reads are read-first (old data).

module generic_sram_dp #(
    parameter int abits = 10,
    parameter int dbits = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [abits-1:0] a0,
    input  logic [dbits-1:0] d0,
    input  logic             we0,
    output logic [dbits-1:0] q0,
    input  logic [abits-1:0] a1,
    input  logic [dbits-1:0] d1,
    input  logic             we1,
    output logic [dbits-1:0] q1
);

    localparam int depth = 2 ** abits;

    logic [dbits-1:0] mem [depth];

    // Value each port will capture into its read register at the next edge
    logic [dbits-1:0] rd0;
    logic [dbits-1:0] rd1;

`ifdef GENERIC_SRAM_WRITE_FIRST_EN
    // Forward the word as it will be after this edge's writes (port 1 has priority)
    always_comb begin
        rd0 = mem[a0];
        rd1 = mem[a1];
        if (we0) begin
            rd0 = d0;
        end
        if (we0 && (a0 == a1)) begin
            rd1 = d0;
        end
        if (we1) begin
            rd1 = d1;
        end
        if (we1 && (a1 == a0)) begin
            rd0 = d1;
        end
    end
`else
    // Read-first: both ports see the word as it was before this edge
    always_comb begin
        rd0 = mem[a0];
        rd1 = mem[a1];
    end
`endif

    // Array writes (port 1 last so it wins a collision) and registered read data; reset clears only q
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            if (we0) begin
                mem[a0] <= d0;
            end
            if (we1) begin
                mem[a1] <= d1;
            end
            q0 <= rd0;
            q1 <= rd1;
        end
    end

endmodule

// File: tb/tb_generic_sram_dp.sv
// tb_generic_sram_dp
// Directed and randomized stimulus for generic_sram_dp. Expected data comes
// from a word-array model. Each cycle the model computes the array before and
// after that cycle's writes. Read-first ports return the old word. Write-first
// ports (GENERIC_SRAM_WRITE_FIRST_EN) return the new word.

module tb_generic_sram_dp;

    localparam int abits = 10;
    localparam int dbits = 16;
    localparam int depth = 2 ** abits;

    logic             clk;
    logic             rstn;
    logic [abits-1:0] a0;
    logic [dbits-1:0] d0;
    logic             we0;
    logic [dbits-1:0] q0;
    logic [abits-1:0] a1;
    logic [dbits-1:0] d1;
    logic             we1;
    logic [dbits-1:0] q1;

    logic [dbits-1:0] model [depth];
    logic [dbits-1:0] expQ0;
    logic [dbits-1:0] expQ1;

    int nCompared;
    int nMismatched;

    generic_sram_dp #(.abits(abits), .dbits(dbits)) dut (
        .clk (clk),
        .rstn(rstn),
        .a0  (a0),
        .d0  (d0),
        .we0 (we0),
        .q0  (q0),
        .a1  (a1),
        .d1  (d1),
        .we1 (we1),
        .q1  (q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the model, counting any mismatch
    task automatic checkOutput(input string tag, input logic [dbits-1:0] observed,
                               input logic [dbits-1:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of port activity, advance the model, and check both q outputs after the edge
    task automatic applyStimulus(input string tag,
                                 input logic [abits-1:0] pa0, input logic [dbits-1:0] pd0, input logic pwe0,
                                 input logic [abits-1:0] pa1, input logic [dbits-1:0] pd1, input logic pwe1);
        logic [dbits-1:0] oldA0;
        logic [dbits-1:0] oldA1;
        a0  = pa0;
        d0  = pd0;
        we0 = pwe0;
        a1  = pa1;
        d1  = pd1;
        we1 = pwe1;
        oldA0 = model[pa0];
        oldA1 = model[pa1];
        if (pwe0) model[pa0] = pd0;
        if (pwe1) model[pa1] = pd1;
`ifdef GENERIC_SRAM_WRITE_FIRST_EN
        expQ0 = model[pa0];
        expQ1 = model[pa1];
`else
        expQ0 = oldA0;
        expQ1 = oldA1;
`endif
        @(posedge clk);
        #1;
        checkOutput({tag, ".q0"}, q0, expQ0);
        checkOutput({tag, ".q1"}, q1, expQ1);
    endtask

    initial begin
        logic [abits-1:0] ra0;
        logic [abits-1:0] ra1;
        logic [dbits-1:0] rd0;
        logic [dbits-1:0] rd1;
        logic             rw0;
        logic             rw1;
        nCompared   = 0;
        nMismatched = 0;
        rstn = 1'b0;
        a0 = '0; d0 = '0; we0 = 1'b0;
        a1 = '0; d1 = '0; we1 = 1'b0;

        // Reset state at time zero
        #2;
        checkOutput("reset0.q0", q0, 16'h0000);
        checkOutput("reset0.q1", q1, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("resetHold.q0", q0, 16'h0000);
        checkOutput("resetHold.q1", q1, 16'h0000);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic write then cross-port read one cycle later
        applyStimulus("basicWr", 10'd3, 16'hA5A5, 1'b1, 10'd4, 16'h0000, 1'b0);
        applyStimulus("basicRd", 10'd0, 16'h0000, 1'b0, 10'd3, 16'h0000, 1'b0);
        checkOutput("basicConst.q1", q1, 16'hA5A5);

        // Same-port read-modify-write
        applyStimulus("rmwInit", 10'd7, 16'h1111, 1'b1, 10'd8, 16'h0000, 1'b0);
        applyStimulus("rmwWr",   10'd7, 16'h2222, 1'b1, 10'd8, 16'h0000, 1'b0);
`ifdef GENERIC_SRAM_WRITE_FIRST_EN
        checkOutput("rmwConst.q0", q0, 16'h2222);
`else
        checkOutput("rmwConst.q0", q0, 16'h1111);
`endif
        applyStimulus("rmwRd",   10'd7, 16'h0000, 1'b0, 10'd8, 16'h0000, 1'b0);
        checkOutput("rmwRdConst.q0", q0, 16'h2222);

        // Cross-port read during write
        applyStimulus("xInit", 10'd9, 16'h0F0F, 1'b1, 10'd2, 16'h0000, 1'b0);
        applyStimulus("xWr",   10'd9, 16'hF0F0, 1'b1, 10'd9, 16'h0000, 1'b0);
`ifdef GENERIC_SRAM_WRITE_FIRST_EN
        checkOutput("xConst.q1", q1, 16'hF0F0);
`else
        checkOutput("xConst.q1", q1, 16'h0F0F);
`endif

        // Write collision: port 1 wins
        applyStimulus("collWr", 10'd12, 16'hAAAA, 1'b1, 10'd12, 16'hBBBB, 1'b1);
        applyStimulus("collRd", 10'd12, 16'h0000, 1'b0, 10'd12, 16'h0000, 1'b0);
        checkOutput("collConst.q0", q0, 16'hBBBB);

        // Extreme addresses written together on different ports, then neighbour aliasing checks
        applyStimulus("extWr",  10'd0,    16'hFFFF, 1'b1, 10'd1023, 16'h8001, 1'b1);
        applyStimulus("extNb",  10'd1,    16'h1234, 1'b1, 10'd1022, 16'h4321, 1'b1);
        applyStimulus("extRd",  10'd1023, 16'h0000, 1'b0, 10'd0,    16'h0000, 1'b0);
        checkOutput("extConst.q0", q0, 16'h8001);
        checkOutput("extConst.q1", q1, 16'hFFFF);
        applyStimulus("extRdNb", 10'd1, 16'h0000, 1'b0, 10'd1022, 16'h0000, 1'b0);

        // Input changes between edges do not disturb the registered outputs
        a0 = 10'd3; a1 = 10'd12; we0 = 1'b1; d0 = 16'hDEAD;
        #3;
        checkOutput("glitch.q0", q0, expQ0);
        checkOutput("glitch.q1", q1, expQ1);
        we0 = 1'b0;

        // Asynchronous reset mid-cycle with data in the array, then retention check
        applyStimulus("preRst", 10'd5, 16'h5A5A, 1'b1, 10'd6, 16'h0000, 1'b0);
        applyStimulus("preRst2", 10'd5, 16'h0000, 1'b0, 10'd5, 16'h0000, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rstAsync.q0", q0, 16'h0000);
        checkOutput("rstAsync.q1", q1, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("rstHeld.q0", q0, 16'h0000);
        checkOutput("rstHeld.q1", q1, 16'h0000);
        #2;
        rstn = 1'b1;
        applyStimulus("postRst", 10'd5, 16'h0000, 1'b0, 10'd5, 16'h0000, 1'b0);
        checkOutput("postRstConst.q0", q0, 16'h5A5A);

        // Randomized traffic concentrated on a few addresses plus the extremes to provoke collisions
        for (int i = 0; i < 400; i++) begin
            ra0 = ($urandom_range(0, 9) < 2) ? (($urandom_range(0, 1) == 0) ? 10'd0 : 10'd1023)
                                             : 10'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 9) < 2) ? (($urandom_range(0, 1) == 0) ? 10'd0 : 10'd1023)
                                             : 10'($urandom_range(0, 15));
            rd0 = 16'($urandom);
            rd1 = 16'($urandom);
            rw0 = 1'($urandom_range(0, 1));
            rw1 = 1'($urandom_range(0, 1));
            applyStimulus("rand", ra0, rd0, rw0, ra1, rd1, rw1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
